seg_scan_sched: RTL
===================

Name: seg_scan_sched

Overview:
Time-multiplexing scheduler for the 8-digit 7-segment display datapath. It holds a 8x5-bit digit register file that any producer can write. It walks a digit pointer through the active digits and drives the digit select (`which`), the segment pattern (`seg`) and the display enable (`enable`). A short blanking gap is inserted between digits to suppress ghosting. SW[1:0] picks the scan mode; the block sits between the board switches/digit producers and the display pins.

Parameters:
TICK_DIV, 2, clock cycles each digit is shown (SHOW phase length), >=1
BLANK_CYC, 1, clock cycles of blanking between digits (BLANK phase length), >=1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
SW  in  2  mode select: 00 off, 01 scan digits 0-3, 10 scan digits 0-7, 11 lamp test
wr_en  in  1  digit register write strobe
wr_addr  in  3  digit index to write
wr_data  in  5  bit4 = decimal point, bits3:0 = hex value
which  out  3  currently selected digit index
seg  out  8  segment pattern {dp,g,f,e,d,c,b,a}, 1 = segment lit
enable  out  1  1 = selected digit driven

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: which=0, seg=8'h00, enable=0, state=IDLE, ptr=0, phase counter=0, all digit registers=5'h00.
- Output timing: all outputs are registered, so they reflect the state/ptr/register contents of the previous cycle.
- Write port:
  - Writes occur on any cycle with wr_en=1, in every state and mode.
  - reg[wr_addr] <= wr_data.
  - A write to the displayed digit appears on seg 2 cycles after the wr_en edge (write, then output register).
- Hex decode, bits6:0 of seg for values 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. seg[7] = stored dp bit.
- State machine:
  - IDLE:
    - enable=0, seg=00, which=0.
    - If SW!=00, go to SHOW with ptr=0 and counter=0.
  - SHOW:
    - enable=1, which=ptr, seg=decode(reg[ptr]); in lamp-test mode (SW=11) seg=8'hFF.
    - Counter counts 0..TICK_DIV-1. At TICK_DIV-1, go to BLANK with counter=0.
  - BLANK:
    - enable=0, seg=00, which holds ptr.
    - Counter counts 0..BLANK_CYC-1. At BLANK_CYC-1, advance ptr and go to SHOW with counter=0.
- Pointer advance:
  - SW=01: ptr wraps 3 -> 0. If ptr>3 at an advance, for example after a mode switch from 10, next ptr=0.
  - SW=10/11: ptr wraps 7 -> 0.
- Mode sampling:
  - SW=00 in any state forces IDLE on the next edge, aborting the current slot.
  - Changes among 01/10/11 take effect immediately for seg content. The scan range change applies at the next pointer advance; the slot is not restarted.
- Slot period: TICK_DIV+BLANK_CYC cycles. Full frame is 4 or 8 slots.
- Reset mid-scan: immediate return to reset values; digit registers are cleared.
- Write and display of the same digit in the same cycle: the display shows the old value that cycle and the new value from the next cycle.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- When defined, in SW=01 or 10 modes, digit k (k>=1) shows seg=00 during SHOW when:
  - its value is 0 and dp=0, and
  - every higher digit within the active range also has value 0 and dp=0.
  - enable remains 1 in this case.
- Digit 0 is never blanked; lamp test is unaffected.
- When not defined, every digit is decoded normally.

Test Plan:
- Reset held 20ns, then SW=01, regs 0..3 = 1,2,3,4 → repeating which 0,0,-,1,1,-,2,2,-,3,3,- with enable 1,1,0. seg = 06,06,00,5B,5B,00,4F... Frame period 12 cycles, which never >3.
- SW=10 after a 10ns reset → all regs 0, so seg=3F for all 8 digits; which sequence 0..7 then wraps to 0. With SEG_LZB_EN, digits 7..1 give seg=00 with enable=1 and digit 0 gives 3F.
- SW=11 → seg=FF in every SHOW cycle, 00 in BLANK; which cycles 0..7.
- Write wr_addr=ptr, wr_data=5'h1A during SHOW → seg becomes F7 (dp plus the value-A pattern 77) 2 cycles after the strobe.
- SW 10 → 00 mid-SHOW → next cycle enable=0, which=0, seg=00. Returning to 01 restarts at which=0.
- Assert rst mid-BLANK with ptr=5 → outputs clear asynchronously, before the next clock edge. After release with SW=10, scan restarts at which=0 with all registers showing 3F.

Source files
------------

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - 8-digit 7-segment scan scheduler with blanking gap
// Optional leading-zero blanking enabled by defining SEG_LZB_EN.
module seg_scan_sched #(
  parameter int TICK_DIV  = 2,
  parameter int BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] SW,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [2:0] which,
  output logic [7:0] seg,
  output logic       enable
);

  localparam int MAXC = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    regs_q [8];
  logic [4:0]    regs_d [8];
  logic [2:0]    which_q, which_d;
  logic [7:0]    seg_q, seg_d;
  logic          enable_q, enable_d;
  logic [2:0]    ptr_adv;
  logic          lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEG_LZB_EN
  logic [7:0] lz_mask;
  logic       lz_run;
  // A digit is blanked only if it and every higher digit in the scan range is a bare zero.
  always_comb begin
    lz_mask = 8'h00;
    lz_run  = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (SW == 2'b10 || i <= 3) begin
        lz_run     = lz_run & (regs_q[i] == 5'h00);
        lz_mask[i] = lz_run;
      end
    end
    lz_blank = lz_mask[ptr_q] && (SW != 2'b11);
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Narrow mode wraps at 3, and also snaps back to 0 if the pointer was left beyond it.
  assign ptr_adv = (SW == 2'b01) ? ((ptr_q >= 3'd3) ? 3'd0 : ptr_q + 3'd1) : ptr_q + 3'd1;

  always_comb begin
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    if (wr_en) regs_d[wr_addr] = wr_data;

    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (SW == 2'b00) begin
      state_d = IDLE;
      ptr_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          ptr_d   = 3'd0;
          cnt_d   = '0;
        end
        SHOW: begin
          if (cnt_q == CW'(TICK_DIV - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == CW'(BLANK_CYC - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
            ptr_d   = ptr_adv;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    which_d  = 3'd0;
    seg_d    = 8'h00;
    enable_d = 1'b0;
    if (SW != 2'b00) begin
      if (state_q == SHOW) begin
        which_d  = ptr_q;
        enable_d = 1'b1;
        if (SW == 2'b11)   seg_d = 8'hFF;
        else if (lz_blank) seg_d = 8'h00;
        else               seg_d = {regs_q[ptr_q][4], hex7(regs_q[ptr_q][3:0])};
      end else if (state_q == BLANK) begin
        which_d = ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 3'd0;
      cnt_q    <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 5'h00;
      which_q  <= 3'd0;
      seg_q    <= 8'h00;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      which_q  <= which_d;
      seg_q    <= seg_d;
      enable_q <= enable_d;
    end
  end

  assign which  = which_q;
  assign seg    = seg_q;
  assign enable = enable_q;

endmodule
